encoder_8_to_3_rr: RTL and testbench
====================================

ENCODER_8_TO_3_RR -- requirements
Module: encoder_8_to_3_rr

Interface
REQ-001: Parameter N, default 8, number of request lines; this block SHALL support only N = 8.
REQ-002: Parameter W, default 3, encoded index width; this block SHALL support only W = 3.
REQ-003: clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: ena  input  1  capture enable; low blocks new grants without disturbing a held grant.
REQ-006: req  input  8  level request lines, bit i = requester i.
REQ-007: ready  input  1  consumer accepts the current index when high with valid.
REQ-008: out  output  3  registered binary index of the granted requester.
REQ-009: valid  output  1  registered; high while out holds an unaccepted grant.

Function
REQ-010: Two states SHALL exist, IDLE and GRANT; reset state is IDLE.
REQ-011: The block SHALL hold a 3-bit round-robin pointer ptr; search order is ptr, ptr+1, ... mod 8.
REQ-012: In IDLE with ena=1 and req!=0, the next edge SHALL load out with the first set bit in search order, set valid=1 and enter GRANT.
REQ-013: In IDLE with ena=0 or req=0, the block SHALL stay in IDLE with valid=0 and out unchanged.
REQ-014: Grant latency SHALL be exactly one cycle from the sampling edge to valid high.
REQ-015: In GRANT, out and valid SHALL stay stable until valid&&ready is sampled high, regardless of req or ena changes.
REQ-016: On handshake, the next edge SHALL clear valid, set ptr = out+1 mod 8 (7 wraps to 0) and return to IDLE.
REQ-017: Throughput SHALL be at most one grant per two cycles; no back-to-back grants.
REQ-018: A request dropped while its grant is held SHALL NOT cancel the grant.
REQ-019: ready while valid=0 SHALL have no effect.
REQ-020: req=8'hFF held with ready=1 SHALL yield grants 0,1,...,7,0 in order.

Reset
REQ-021: While rst_n=0, the block SHALL force state=IDLE, valid=0, out=3'd0, ptr=3'd0, immediately and regardless of clk.
REQ-022: Reset asserted in GRANT SHALL drop the held grant; no handshake SHALL occur for it.
REQ-023: After rst_n rises, the first grant SHALL be possible on the first edge with ena=1 and req!=0.

Structure
REQ-024: Package encoder_pkg SHALL hold N, W and the state enum (IDLE, GRANT).
REQ-025: Sub-module priority_encoder_8_to_3 SHALL be purely combinational: lowest-index fixed priority, with inputs in[7:0] and outputs out[2:0] and any; the top level SHALL apply it to req rotated right by ptr and add ptr mod 8 to its result.
REQ-026: Only the top level SHALL contain flops.

Verification
REQ-027: rst_n=0 with req=8'hFF, ena=1 -> valid=0 and out=0 throughout; after release, valid=1 with out=0 one edge later.
REQ-028: req=8'b0000_0100, ena=1, ready=1 -> valid=1 and out=2 after one edge; valid=0 next edge; a following req=8'hFF grants 3.
REQ-029: req=8'hFF, ready=1 continuously -> out sequence 0..7,0 with valid high every other cycle.
REQ-030: Grant out=5 held with ready=0 for 6 cycles while req toggles to 8'h00 -> out=5 and valid=1 stable; ready=1 -> valid=0 next edge.
REQ-031: After a grant of 6 (ptr=7), req=8'b0000_0011 -> out=0, confirming wrap-around.
REQ-032: ena=0 with req=8'h80 for 4 cycles -> valid stays 0; ena=1 -> out=7 one edge later; rst_n pulsed low mid-grant -> valid=0 at once and out=0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared sizing and FSM state type for the round-robin 8-to-3 encoder.
// No logic of its own; zero latency.
// No flow control; types and constants only.
package encoder_pkg;

    localparam int N = 8;   // request lines
    localparam int W = 3;   // encoded index width

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage : encoder_pkg

// File: rtl/encoder_8_to_3_rr_prio.sv
// Fixed-priority 8-to-3 encoder: lowest set input index wins.
// Purely combinational, zero latency.
// No flow control; any flags whether any input is set.
module priority_encoder_8_to_3
    import encoder_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        out = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                out = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : priority_encoder_8_to_3

// File: rtl/encoder_8_to_3_rr.sv
// Round-robin 8-to-3 request encoder with a held, registered grant index.
// Grant appears one edge after sampling; at most one grant per two cycles.
// Grant holds (out/valid stable) until valid&&ready; ready with valid low is ignored.
module encoder_8_to_3_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic         valid
);

    import encoder_pkg::*;

    state_e         state_q, state_d;
    logic [W-1:0]   out_q,   out_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   ptr_q,   ptr_d;

    logic [N-1:0]   req_rot;
    logic [W-1:0]   pe_out;
    logic           pe_any;
    logic [W-1:0]   grant_idx;

    // Rotate requests right by ptr so bit 0 of req_rot is the requester at ptr.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N; i++) begin
            req_rot[i] = req[ptr_q + W'(i)];
        end
    end

    priority_encoder_8_to_3 u_prio (
        .in  (req_rot),
        .out (pe_out),
        .any (pe_any)
    );

    // Undo the rotation; the 3-bit add wraps modulo 8 on its own.
    assign grant_idx = pe_out + ptr_q;

    // Next-state: capture a grant from IDLE, release it on handshake in GRANT.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (ena && pe_any) begin
                    out_d   = grant_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // req and ena are deliberately ignored while a grant is held.
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    ptr_d   = out_q + W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any held grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule : encoder_8_to_3_rr

// File: tb/tb_encoder_8_to_3_rr.sv
// Self-checking bench for encoder_8_to_3_rr: directed scenarios plus random traffic.
// Outputs compared every negedge against a behavioural model.
// Consumer ready is driven randomly to exercise grant holding.
module tb_encoder_8_to_3_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ready = 1'b0;
    logic [2:0] out;
    logic       valid;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    bit m_busy = 1'b0;
    int m_out  = 0;
    int m_ptr  = 0;

    encoder_8_to_3_rr #(.N(8), .W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .req   (req),
        .ready (ready),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Model: search ptr, ptr+1, ... mod 8 for the first request; hold until accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_out  = 0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (ready) begin
                m_busy = 1'b0;
                m_ptr  = (m_out + 1) % 8;
            end
        end else if (ena && req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (req[(m_ptr + k) % 8]) begin
                    m_out  = (m_ptr + k) % 8;
                    m_busy = 1'b1;
                    break;
                end
            end
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid", int'(valid), int'(m_busy));
            chk("model_out", int'(out), m_out);
        end
    end

    initial begin
        // Reset held with full requests: nothing granted.
        rst_n = 1'b0; req = 8'hFF; ena = 1'b1; ready = 1'b0;
        tick();
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", int'(valid), 0);
            chk("rst_out", int'(out), 0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_out", int'(out), 0);

        // Single request at 2, then pointer moves to 3.
        do_reset();
        req = 8'b0000_0100; ena = 1'b1; ready = 1'b1;
        tick();
        chk("single_valid", int'(valid), 1);
        chk("single_out", int'(out), 2);
        req = 8'hFF;
        tick();
        chk("single_ack_valid", int'(valid), 0);
        tick();
        chk("next_after2_out", int'(out), 3);
        chk("next_after2_valid", int'(valid), 1);

        // Full requests with ready: 0..7,0 every other cycle.
        do_reset();
        req = 8'hFF; ena = 1'b1; ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("seq_valid_hi", int'(valid), 1);
            chk("seq_out", int'(out), k % 8);
            tick();
            chk("seq_valid_lo", int'(valid), 0);
        end

        // Grant of 5 held against req/ena churn while ready is low.
        do_reset();
        req = 8'h20; ena = 1'b1; ready = 1'b0;
        tick();
        chk("hold_first_out", int'(out), 5);
        for (int i = 0; i < 6; i++) begin
            req = (i % 2 == 0) ? 8'h00 : 8'hFF;
            ena = (i % 3 != 0);
            tick();
            chk("hold_out", int'(out), 5);
            chk("hold_valid", int'(valid), 1);
        end
        ready = 1'b1; req = 8'h00;
        tick();
        chk("hold_release_valid", int'(valid), 0);
        chk("hold_release_out", int'(out), 5);

        // Pointer wrap: after grant 6, ptr=7, so req bits 0/1 grant 0.
        do_reset();
        req = 8'h40; ena = 1'b1; ready = 1'b1;
        tick();
        chk("wrap_g6", int'(out), 6);
        req = 8'b0000_0011;
        tick();
        chk("wrap_ack", int'(valid), 0);
        tick();
        chk("wrap_out", int'(out), 0);
        chk("wrap_valid", int'(valid), 1);

        // Enable gating, then asynchronous reset in the middle of a grant.
        do_reset();
        ena = 1'b0; req = 8'h80; ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ena_off_valid", int'(valid), 0);
        end
        ena = 1'b1;
        tick();
        chk("ena_on_out", int'(out), 7);
        chk("ena_on_valid", int'(valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_out", int'(out), 0);
        tick();
        rst_n = 1'b1;

        // Random traffic, including occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            tick();
            ready = ($urandom_range(0, 2) != 0);
            ena   = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 3) == 0)
                req = 8'h00;
            else if ($urandom_range(0, 2) == 0)
                req = 8'(1 << $urandom_range(0, 7));
            else
                req = 8'($urandom);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        rst_n = 1'b1;
        tick();
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_encoder_8_to_3_rr
